fifo_pop_packer: RTL and testbench
==================================

FIFO_POP_PACKER -- requirements
Module: fifo_pop_packer

Interface
REQ-001: Parameter DATA_WIDTH, default 32, SHALL set the width of one FIFO word.
REQ-002: Parameter PACK_RATIO, default 4, SHALL set the number of FIFO words per output beat; legal values are >= 2.
REQ-003: Parameter TIMEOUT, default 16, SHALL set the idle cycles before a partial beat is emitted; 0 disables the timeout.
REQ-004: clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005: rst_ni  input  1  SHALL be the asynchronous, active-low reset.
REQ-006: flush_i  input  1  SHALL be a synchronous clear that discards all held data.
REQ-007: fifo_empty_i  input  1  SHALL be the empty flag of the upstream FIFO.
REQ-008: fifo_data_i  input  DATA_WIDTH  SHALL be the head word of the upstream FIFO.
REQ-009: fifo_pop_o  output  1  SHALL be the pop request to the upstream FIFO.
REQ-010: data_o  output  DATA_WIDTH*PACK_RATIO  SHALL be the packed output beat.
REQ-011: strb_o  output  PACK_RATIO  SHALL give one valid bit per lane of data_o.
REQ-012: valid_o  output  1  SHALL flag a beat on data_o/strb_o.
REQ-013: ready_i  input  1  SHALL be the downstream acceptance signal.

Function
REQ-014: The block SHALL implement two states: FILL (collecting words) and SEND (holding a beat with valid_o=1).
REQ-015: In FILL, fifo_pop_o SHALL equal !fifo_empty_i && !flush_i.
REQ-016: A popped word SHALL be written to lane cnt (lane 0 = data_o[DATA_WIDTH-1:0]), strb_o[cnt] SHALL be set, and cnt SHALL increment.
REQ-017: A pop into lane PACK_RATIO-1 SHALL move the block to SEND on the next edge, with strb_o all ones.
REQ-018: In FILL with cnt>0, an idle counter SHALL increment on each cycle without a pop and clear on each pop.
REQ-019: When the idle counter reaches TIMEOUT (TIMEOUT>0), the block SHALL move to SEND with the partial strobe.
REQ-020: In FILL with cnt==0, the idle counter SHALL stay 0 and no beat SHALL be emitted.
REQ-021: valid_o SHALL be 1 exactly in SEND.
REQ-022: data_o and strb_o SHALL be stable while valid_o && !ready_i.
REQ-023: Lanes with strb_o=0 SHALL drive zero on data_o.
REQ-024: In SEND, fifo_pop_o SHALL equal ready_i && !fifo_empty_i && !flush_i.
REQ-025: On a SEND handshake (valid_o && ready_i), strobes SHALL clear and the block SHALL return to FILL.
REQ-026: If a pop also occurs in that handshake cycle, the popped word SHALL land in lane 0 with cnt=1, allowing back-to-back beats with no bubble on the pop side.
REQ-027: In SEND without ready_i, fifo_pop_o SHALL be 0 and no state SHALL change.
REQ-028: fifo_pop_o SHALL never be asserted while fifo_empty_i=1.
REQ-029: flush_i=1 SHALL force the next state to FILL with cnt=0, idle=0, strb_o=0 and valid_o=0, and SHALL drop any pending beat even if ready_i=1.
REQ-030: flush_i SHALL take priority over pop, timeout and handshake in the same cycle.
REQ-031: The cnt and idle counter widths SHALL be $clog2(PACK_RATIO) and $clog2(TIMEOUT+1) (minimum 1), and SHALL never wrap.

Reset
REQ-032: While rst_ni=0, regardless of the clock, the block SHALL be in FILL with cnt=0, idle=0, strb_o=0, data_o=0, valid_o=0.
REQ-033: fifo_pop_o SHALL be 0 while rst_ni=0.
REQ-034: Reset asserted mid-packet or mid-SEND SHALL discard all held words, and no beat SHALL appear after release until new pops occur.

Verification (DATA_WIDTH=8, PACK_RATIO=4, TIMEOUT=3)
REQ-035: Push 0x11,0x22,0x33,0x44 with ready_i=1 -> 4 pops, then valid_o=1 with data_o=0x44332211 and strb_o=4'b1111.
REQ-036: Push only 0xAA and hold the FIFO empty -> valid_o rises after 3 idle cycles with data_o=0x000000AA and strb_o=4'b0001.
REQ-037: Continuous stream of 8 words with ready_i=1 -> two beats, the 5th word popped in the first beat's handshake cycle, and no pop-side bubble.
REQ-038: Full beat held with ready_i=0 for 5 cycles -> fifo_pop_o=0, data_o stable; accepted on the cycle ready_i rises.
REQ-039: flush_i asserted with cnt=2, and again during SEND with ready_i=1 -> next cycle strb_o=0, valid_o=0, and no beat is emitted.
REQ-040: rst_ni pulsed low during SEND -> outputs go to zero immediately (asynchronously); after release the first beat contains only post-reset words.

Source files
------------

// File: rtl/fifo_pop_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pop_packer
// Brief    : Pops words from an upstream FIFO and packs PACK_RATIO of them
//            into one strobed output beat, with an idle timeout for partials.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_pop_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int PACK_RATIO = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic                             fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]            fifo_data_i,
  output logic                             fifo_pop_o,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] data_o,
  output logic [PACK_RATIO-1:0]            strb_o,
  output logic                             valid_o,
  input  logic                             ready_i
);

  localparam int CNT_W  = ($clog2(PACK_RATIO) > 0) ? $clog2(PACK_RATIO) : 1;
  localparam int IDLE_W = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CNT_W-1:0]  c_last_lane = CNT_W'(PACK_RATIO - 1);
  localparam logic [IDLE_W-1:0] c_timeout   = IDLE_W'(TIMEOUT);
  localparam bit                c_to_en     = (TIMEOUT != 0);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                           r_state;
  logic [CNT_W-1:0]                 r_cnt;
  logic [IDLE_W-1:0]                r_idle;
  logic [PACK_RATIO-1:0]            r_strb;
  logic [DATA_WIDTH*PACK_RATIO-1:0] r_data;

  logic                  w_pop;
  logic                  w_timeout_hit;
  logic [PACK_RATIO-1:0] w_lane_sel;

  // Reset gates the pop so the upstream FIFO is never drained during reset.
  always_comb begin
    w_pop = rst_ni && !flush_i && !fifo_empty_i && ((r_state == FILL) || ready_i);
  end

  always_comb begin
    w_timeout_hit = c_to_en && ((r_idle + IDLE_W'(1)) == c_timeout);
  end

  // A pop during the SEND handshake always starts the next beat in lane 0.
  always_comb begin
    w_lane_sel = '0;
    if (r_state == SEND) begin
      w_lane_sel = PACK_RATIO'(1);
    end else begin
      for (int l = 0; l < PACK_RATIO; l++) begin
        if (r_cnt == CNT_W'(l)) begin
          w_lane_sel[l] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_idle  <= '0;
      r_strb  <= '0;
      r_data  <= '0;
    end else if (flush_i) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_idle  <= '0;
      r_strb  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_pop) begin
            for (int l = 0; l < PACK_RATIO; l++) begin
              if (w_lane_sel[l]) begin
                r_data[l*DATA_WIDTH +: DATA_WIDTH] <= fifo_data_i;
              end
            end
            r_strb <= r_strb | w_lane_sel;
            r_idle <= '0;
            if (r_cnt == c_last_lane) begin
              r_cnt   <= '0;
              r_state <= SEND;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else if ((r_cnt != '0) && c_to_en) begin
            // Idle count stops at TIMEOUT because the beat leaves FILL here.
            r_idle <= r_idle + IDLE_W'(1);
            if (w_timeout_hit) begin
              r_cnt   <= '0;
              r_state <= SEND;
            end
          end
        end
        SEND: begin
          if (ready_i) begin
            r_state <= FILL;
            r_idle  <= '0;
            r_cnt   <= '0;
            r_strb  <= '0;
            r_data  <= '0;
            if (w_pop) begin
              r_data[DATA_WIDTH-1:0] <= fifo_data_i;
              r_strb                 <= w_lane_sel;
              r_cnt                  <= CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign fifo_pop_o = w_pop;
  assign data_o     = r_data;
  assign strb_o     = r_strb;
  assign valid_o    = (r_state == SEND);

endmodule
`default_nettype wire

// File: tb/tb_fifo_pop_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_pop_packer
// Brief    : Self-checking bench for fifo_pop_packer against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_pop_packer;

  localparam int DW = 8;
  localparam int PR = 4;
  localparam int TO = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          empty = 1'b1;
  logic          ready = 1'b0;
  logic [DW-1:0] fdata = '0;
  logic          pop;
  logic [31:0]   data;
  logic [3:0]    strb;
  logic          valid;

  always #5 clk = ~clk;

  fifo_pop_packer #(
    .DATA_WIDTH (DW),
    .PACK_RATIO (PR),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .fifo_empty_i (empty),
    .fifo_data_i  (fdata),
    .fifo_pop_o   (pop),
    .data_o       (data),
    .strb_o       (strb),
    .valid_o      (valid),
    .ready_i      (ready)
  );

  int errs   = 0;
  int checks = 0;

  logic [7:0] src[$];
  logic [7:0] m_words[$];
  bit         m_send = 1'b0;
  int         m_idle = 0;
  bit         prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  int         pop_count = 0;
  int         beat_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_data();
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < m_words.size(); i++) d[i*8 +: 8] = m_words[i];
    return d;
  endfunction

  function automatic logic [3:0] m_strb();
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < m_words.size(); i++) s[i] = 1'b1;
    return s;
  endfunction

  task automatic model_clear();
    m_words.delete();
    m_send = 1'b0;
    m_idle = 0;
  endtask

  // One clock: drive at negedge, compare, then advance model at posedge.
  task automatic cycle(input bit f, input bit r, input bit h);
    bit         ep;
    logic [7:0] w;
    flush = f;
    ready = r;
    empty = h || (src.size() == 0);
    fdata = (src.size() > 0) ? src[0] : 8'h00;
    #1;
    ep = rst_n && !f && !empty && (!m_send || r);
    chk("pop", pop, ep);
    chk("valid", valid, m_send);
    chk("data", data, m_data());
    chk("strb", strb, m_strb());
    if (prev_hold) chk("hold_stable", data, prev_data);
    prev_hold = rst_n && m_send && !r && !f;
    prev_data = data;
    if (ep) pop_count++;
    if (rst_n && !f && m_send && r) beat_count++;
    @(posedge clk);
    w = fdata;
    if (!rst_n || f) begin
      model_clear();
    end else if (m_send) begin
      if (r) begin
        model_clear();
        if (ep) m_words.push_back(w);
      end
    end else if (ep) begin
      m_words.push_back(w);
      m_idle = 0;
      if (m_words.size() == PR) m_send = 1'b1;
    end else if (m_words.size() > 0) begin
      m_idle++;
      if (m_idle == TO) m_send = 1'b1;
    end
    if (ep) void'(src.pop_front());
    @(negedge clk);
  endtask

  initial begin
    int pc0;
    int bc0;
    @(negedge clk);
    // Reset with a non-empty FIFO: nothing may pop.
    src.push_back(8'h5A);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_strb", strb, 4'h0);
    chk("rst_data", data, 32'h0);
    src.delete();
    rst_n = 1'b1;
    cycle(0, 1, 0);

    // Full beat of four words.
    src = '{8'h11, 8'h22, 8'h33, 8'h44};
    pc0 = pop_count;
    repeat (4) cycle(0, 1, 0);
    chk("full_pops", pop_count - pc0, 4);
    chk("full_valid", valid, 1'b1);
    chk("full_data", data, 32'h44332211);
    chk("full_strb", strb, 4'b1111);
    cycle(0, 1, 0);

    // Partial beat released by the idle timeout.
    src.push_back(8'hAA);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    chk("to_early_valid", valid, 1'b0);
    cycle(0, 1, 0);
    chk("to_valid", valid, 1'b1);
    chk("to_data", data, 32'h000000AA);
    chk("to_strb", strb, 4'b0001);
    cycle(0, 1, 0);

    // Eight-word stream: no pop bubble across the first handshake.
    for (int i = 1; i <= 8; i++) src.push_back(8'(i));
    pc0 = pop_count;
    bc0 = beat_count;
    repeat (8) cycle(0, 1, 0);
    chk("stream_pops", pop_count - pc0, 8);
    chk("stream_data2", data, 32'h08070605);
    cycle(0, 1, 0);
    chk("stream_beats", beat_count - bc0, 2);

    // Backpressure for five cycles, then acceptance with a waiting word.
    src = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0};
    repeat (4) cycle(0, 0, 0);
    pc0 = pop_count;
    repeat (5) cycle(0, 0, 0);
    chk("bp_no_pop", pop_count - pc0, 0);
    chk("bp_data", data, 32'hA3A2A1A0);
    cycle(0, 1, 0);
    chk("bp_next_lane0", data, 32'h000000B0);
    cycle(1, 1, 0);

    // Flush mid-fill, then flush a pending beat with ready high.
    src = '{8'hC0, 8'hC1};
    repeat (2) cycle(0, 1, 0);
    chk("fl_pre_strb", strb, 4'b0011);
    cycle(1, 1, 0);
    chk("fl_fill_strb", strb, 4'h0);
    chk("fl_fill_valid", valid, 1'b0);
    src = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
    repeat (4) cycle(0, 0, 0);
    bc0 = beat_count;
    cycle(1, 1, 0);
    chk("fl_send_valid", valid, 1'b0);
    chk("fl_send_strb", strb, 4'h0);
    chk("fl_send_beats", beat_count - bc0, 0);
    src.delete();
    cycle(0, 1, 0);

    // Asynchronous reset during SEND.
    src = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hEE};
    repeat (4) cycle(0, 0, 0);
    chk("ar_pre_valid", valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", valid, 1'b0);
    chk("ar_data", data, 32'h0);
    chk("ar_strb", strb, 4'h0);
    chk("ar_pop", pop, 1'b0);
    model_clear();
    prev_hold = 1'b0;
    src.delete();
    @(negedge clk);
    cycle(0, 1, 0);
    rst_n = 1'b1;
    src = '{8'hF1, 8'hF2};
    repeat (2) cycle(0, 1, 0);
    repeat (3) cycle(0, 1, 0);
    chk("ar_post_valid", valid, 1'b1);
    chk("ar_post_data", data, 32'h0000F2F1);
    cycle(0, 1, 0);

    // Randomized phases with varying supply rates to reach timeouts too.
    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 1000; n++) begin
        if ($urandom_range(0, 4) < 4 - 2 * ph && src.size() < 16)
          src.push_back(8'($urandom));
        cycle($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 3) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
